cacheline_adaptor: RTL and testbench

Memory-side responder for the eviction write buffer's upper port. It accepts one 256-bit line read or write request from the cache/write-buffer side and serves it to physical memory as a 4-beat, 64-bit burst. On reads it assembles the beats into a line. It returns a single-cycle line response to the requester.

---
 rtl/cacheline_adaptor.sv | 133 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
//   Serves one cache-line read or write request from the requester side
//   as a BEATS-long burst on the memory side. Read beats are assembled
//   into line_o. Each transaction ends with a one-cycle resp_o pulse.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   line_i     write line from requester
//   line_o     assembled read line; held until the next read overwrites it
//   address_i  requester byte address; aligned to a line when latched
//   read_i     requester read request (level, held until resp_o)
//   write_i    requester write request (level, held until resp_o); wins over read_i
//   resp_o     one-cycle completion pulse to requester
//   burst_i    memory read beat
//   burst_o    memory write beat
//   address_o  line-aligned address to memory, valid during a burst
//   read_o     memory read burst request
//   write_o    memory write burst request
//   resp_i     memory beat acknowledge, one per beat
module cacheline_adaptor #(
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LINE_WIDTH-1:0] line_i,
  output logic [LINE_WIDTH-1:0] line_o,
  input  logic [ADDR_WIDTH-1:0] address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  output logic                  resp_o,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  output logic [BEAT_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic                  read_o,
  output logic                  write_o,
  input  logic                  resp_i
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    RESP     = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        count;
  // Write data is kept apart from line_o so a write never disturbs the
  // last assembled read line.
  logic [LINE_WIDTH-1:0]   wr_line;

  // write_o is only high in WR_BURST, so this is zero everywhere else,
  // including while reset is held.
  assign burst_o = write_o ? wr_line[int'(count)*BEAT_WIDTH +: BEAT_WIDTH] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      wr_line   <= '0;
      line_o    <= '0;
      address_o <= '0;
      read_o    <= 1'b0;
      write_o   <= 1'b0;
      resp_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_o <= 1'b0;
          // resp_i is ignored here; write takes priority over read.
          if (write_i) begin
            address_o <= address_i & ALIGN_MASK;
            wr_line   <= line_i;
            count     <= '0;
            write_o   <= 1'b1;
            state     <= WR_BURST;
          end else if (read_i) begin
            address_o <= address_i & ALIGN_MASK;
            count     <= '0;
            read_o    <= 1'b1;
            state     <= RD_BURST;
          end
        end

        RD_BURST: begin
          if (resp_i) begin
            line_o[int'(count)*BEAT_WIDTH +: BEAT_WIDTH] <= burst_i;
            count <= count + 1'b1;
            if (count == LAST_BEAT) begin
              read_o    <= 1'b0;
              address_o <= '0;
              resp_o    <= 1'b1;
              state     <= RESP;
            end
          end
        end

        WR_BURST: begin
          if (resp_i) begin
            count <= count + 1'b1;
            if (count == LAST_BEAT) begin
              write_o   <= 1'b0;
              address_o <= '0;
              resp_o    <= 1'b1;
              state     <= RESP;
            end
          end
        end

        RESP: begin
          // Single-cycle pulse; the requester drops its request on this edge.
          resp_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          resp_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// tb_cacheline_adaptor
//   Directed bench for cacheline_adaptor with a transaction-level reference
//   model and a per-cycle output compare, plus literal expectations.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_checks = 0;
  int n_fail   = 0;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  // kind: 0 = no transfer in flight, 1 = read, 2 = write
  int           m_kind   = 0;
  int           m_beats  = 0;
  bit           m_resp   = 1'b0;
  logic [31:0]  m_addr   = '0;
  logic [255:0] m_wline  = '0;
  logic [255:0] m_line   = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_kind  <= 0;
      m_beats <= 0;
      m_resp  <= 1'b0;
      m_addr  <= '0;
      m_wline <= '0;
      m_line  <= '0;
    end else if (m_resp) begin
      m_resp <= 1'b0;
    end else if (m_kind == 0) begin
      if (write_i) begin
        m_kind  <= 2;
        m_beats <= 0;
        m_addr  <= {address_i[31:5], 5'b0};
        m_wline <= line_i;
      end else if (read_i) begin
        m_kind  <= 1;
        m_beats <= 0;
        m_addr  <= {address_i[31:5], 5'b0};
      end
    end else if (resp_i) begin
      if (m_kind == 1) m_line[m_beats*64 +: 64] <= burst_i;
      m_beats <= m_beats + 1;
      if (m_beats == 3) begin
        m_kind <= 0;
        m_resp <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] exp_burst;
    exp_burst = (m_kind == 2) ? m_wline[m_beats*64 +: 64] : 64'h0;
    chk("cmp_read_o",    {255'h0, read_o},  {255'h0, m_kind == 1});
    chk("cmp_write_o",   {255'h0, write_o}, {255'h0, m_kind == 2});
    chk("cmp_resp_o",    {255'h0, resp_o},  {255'h0, m_resp});
    chk("cmp_address_o", {224'h0, address_o}, {224'h0, (m_kind != 0) ? m_addr : 32'h0});
    chk("cmp_burst_o",   {192'h0, burst_o}, {192'h0, exp_burst});
    chk("cmp_line_o",    line_o, m_line);
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [63:0]  rb_a [4];
  logic [63:0]  rb_b [4];
  logic [63:0]  wd   [4];
  logic [255:0] line_a;
  logic [255:0] line_b;
  logic [255:0] line_w;
  logic [255:0] line_w2;
  logic [63:0]  exp_wr [7];
  logic         pat    [7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rb_a[0] = 64'h1111_1111_1111_1111;
    rb_a[1] = 64'h2222_2222_2222_2222;
    rb_a[2] = 64'h3333_3333_3333_3333;
    rb_a[3] = 64'h4444_4444_4444_4444;
    rb_b[0] = 64'h5555_5555_5555_5555;
    rb_b[1] = 64'h6666_6666_6666_6666;
    rb_b[2] = 64'h7777_7777_7777_7777;
    rb_b[3] = 64'h8888_8888_8888_8888;
    wd[0]   = 64'hD0D0_D0D0_D0D0_D0D0;
    wd[1]   = 64'hD1D1_D1D1_D1D1_D1D1;
    wd[2]   = 64'hD2D2_D2D2_D2D2_D2D2;
    wd[3]   = 64'hD3D3_D3D3_D3D3_D3D3;
    line_a  = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    line_b  = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
               64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
    line_w  = {64'hD3D3_D3D3_D3D3_D3D3, 64'hD2D2_D2D2_D2D2_D2D2,
               64'hD1D1_D1D1_D1D1_D1D1, 64'hD0D0_D0D0_D0D0_D0D0};
    line_w2 = {64'hA3A3_A3A3_A3A3_A3A3, 64'hA2A2_A2A2_A2A2_A2A2,
               64'hA1A1_A1A1_A1A1_A1A1, 64'hA0A0_A0A0_A0A0_A0A0};
    exp_wr  = '{wd[0], wd[1], wd[1], wd[1], wd[2], wd[3], wd[3]};
    pat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_read_o",  {255'h0, read_o},  256'h0);
    chk("rst_write_o", {255'h0, write_o}, 256'h0);
    chk("rst_resp_o",  {255'h0, resp_o},  256'h0);
    chk("rst_line_o",  line_o, 256'h0);
    rst = 1'b1;
    tick();

    // Read, no stalls
    read_i = 1'b1; address_i = 32'h0000_1234;
    tick();
    chk("rd_read_o",    {255'h0, read_o}, 256'h1);
    chk("rd_address_o", {224'h0, address_o}, {224'h0, 32'h0000_1220});
    for (int b = 0; b < 4; b++) begin
      burst_i = rb_a[b]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0; burst_i = '0;
    chk("rd_resp_o",   {255'h0, resp_o}, 256'h1);
    chk("rd_read_off", {255'h0, read_o}, 256'h0);
    chk("rd_line_o",   line_o, line_a);
    chk("model_line_a", m_line, line_a);
    tick();
    read_i = 1'b0;
    chk("rd_resp_once", {255'h0, resp_o}, 256'h0);
    tick();

    // Write with stalls; requester inputs change after sampling
    write_i = 1'b1; line_i = line_w; address_i = 32'hABCD_EF7F;
    tick();
    line_i = '1; address_i = 32'h0;
    for (int i = 0; i < 7; i++) begin
      chk("wr_write_o", {255'h0, write_o}, 256'h1);
      chk("wr_burst_o", {192'h0, burst_o}, {192'h0, exp_wr[i]});
      chk("wr_address_o", {224'h0, address_o}, {224'h0, 32'hABCD_EF60});
      resp_i = pat[i];
      tick();
    end
    resp_i = 1'b0;
    chk("wr_resp_o",     {255'h0, resp_o},  256'h1);
    chk("wr_write_off",  {255'h0, write_o}, 256'h0);
    chk("wr_line_o_kept", line_o, line_a);
    tick();
    write_i = 1'b0;
    chk("wr_resp_once", {255'h0, resp_o}, 256'h0);
    tick();

    // Simultaneous read and write: write wins, read follows afterwards
    read_i = 1'b1; write_i = 1'b1; line_i = line_w2; address_i = 32'h2000_0040;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("both_read_o",  {255'h0, read_o},  256'h0);
      chk("both_write_o", {255'h0, write_o}, 256'h1);
      resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0;
    chk("both_resp_o", {255'h0, resp_o}, 256'h1);
    tick();
    write_i = 1'b0;
    chk("both_idle_read_o", {255'h0, read_o}, 256'h0);
    tick();
    chk("both_then_read_o", {255'h0, read_o}, 256'h1);
    chk("both_then_addr",   {224'h0, address_o}, {224'h0, 32'h2000_0040});
    for (int b = 0; b < 4; b++) begin
      burst_i = rb_b[b]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0; burst_i = '0;
    chk("both_read_line", line_o, line_b);
    chk("model_line_b", m_line, line_b);
    tick();
    read_i = 1'b0;
    tick();

    // Back-to-back reads with spurious resp_i in RESP and IDLE
    read_i = 1'b1; address_i = 32'h0000_0100;
    tick();
    for (int b = 0; b < 4; b++) begin
      burst_i = rb_a[b]; resp_i = 1'b1;
      tick();
    end
    burst_i = '0;
    chk("b2b_resp_o", {255'h0, resp_o}, 256'h1);
    chk("b2b_line_o", line_o, line_a);
    tick();
    read_i = 1'b0;
    chk("b2b_resp_narrow", {255'h0, resp_o}, 256'h0);
    chk("b2b_no_retrig",   {255'h0, read_o}, 256'h0);
    tick();
    chk("spur_idle_read_o", {255'h0, read_o}, 256'h0);
    chk("spur_idle_resp_o", {255'h0, resp_o}, 256'h0);
    chk("spur_idle_line_o", line_o, line_a);
    resp_i = 1'b0; read_i = 1'b1;
    tick();
    chk("b2b_second_read_o", {255'h0, read_o}, 256'h1);
    burst_i = rb_b[0]; resp_i = 1'b1;
    tick();
    chk("b2b_beat0_replace", line_o, {line_a[255:64], rb_b[0]});
    for (int b = 1; b < 4; b++) begin
      burst_i = rb_b[b]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0; burst_i = '0;
    chk("b2b_second_line", line_o, line_b);
    tick();
    read_i = 1'b0;
    tick();

    // Asynchronous reset in the middle of a write burst at beat 2
    write_i = 1'b1; line_i = line_w2; address_i = 32'h0000_0040;
    tick();
    resp_i = 1'b1;
    tick();
    tick();
    resp_i = 1'b0; write_i = 1'b0;
    chk("mid_burst_beat2", {192'h0, burst_o}, {192'h0, 64'hA2A2_A2A2_A2A2_A2A2});
    #2;
    rst = 1'b0;
    #1;
    chk("async_write_o",   {255'h0, write_o}, 256'h0);
    chk("async_resp_o",    {255'h0, resp_o},  256'h0);
    chk("async_burst_o",   {192'h0, burst_o}, 256'h0);
    chk("async_address_o", {224'h0, address_o}, 256'h0);
    chk("async_line_o",    line_o, 256'h0);
    tick(); tick();
    rst = 1'b1;
    read_i = 1'b1; address_i = 32'h3000_001F;
    tick();
    chk("post_rst_read_o", {255'h0, read_o}, 256'h1);
    chk("post_rst_addr",   {224'h0, address_o}, {224'h0, 32'h3000_0000});
    for (int b = 0; b < 4; b++) begin
      burst_i = rb_a[b]; resp_i = 1'b1;
      tick();
    end
    resp_i = 1'b0; burst_i = '0;
    chk("post_rst_resp_o", {255'h0, resp_o}, 256'h1);
    chk("post_rst_line",   line_o, line_a);
    tick();
    read_i = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
